// File: rtl/ddr3_pkg.sv
// Shared definitions for the DDR3 app-interface arbiter: MIG command codes,
// FSM state encoding and a small requester-select helper.
package ddr3_pkg;

   // MIG 7-series app_cmd encodings used by this block
   localparam logic [2:0] APP_CMD_WR = 3'b000;
   localparam logic [2:0] APP_CMD_RD = 3'b001;

   // Arbiter FSM: IDLE chooses a requester, ISSUE runs the MIG handshakes
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } arb_state_t;

   // Turn a requester index (0/1) into a one-hot strobe
   function automatic logic [1:0] onehot2(input logic sel);
      return sel ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/ddr3_tag_fifo.sv
// One-bit-wide tag FIFO recording which requester issued each outstanding
// read. Count is registered so that full/empty reflect the state at the
// start of the cycle, independent of any push/pop happening in it.
module ddr3_tag_fifo #(
   parameter int TAG_DEPTH = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic push,
   input  logic push_tag,
   input  logic pop,
   output logic pop_tag,
   output logic full,
   output logic empty
);

   localparam int PTR_W = $clog2(TAG_DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE  = 1;
   localparam logic [PTR_W:0]   CNT_ONE  = 1;
   localparam logic [PTR_W:0]   CNT_FULL = TAG_DEPTH[PTR_W:0];

   logic             mem [TAG_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_FULL);
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign pop_tag = mem[rd_ptr];

   // Tag storage: write-only on accepted push, no reset needed
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_tag;
      end
   end

   // Pointers and occupancy; simultaneous push and pop leave count unchanged
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/ddr3_app_arbiter.sv
// Two-requester round-robin arbiter in front of the MIG 7-series app
// interface. Grants one single-beat command at a time, runs the app_en and
// app_wdf_wren handshakes independently, and steers in-order read returns
// back to the issuing requester using a tag FIFO.
module ddr3_app_arbiter
   import ddr3_pkg::*;
#(
   parameter int ADDR_W    = 28,
   parameter int DATA_W    = 256,
   parameter int TAG_DEPTH = 16
) (
   input  logic                      ui_clk,
   input  logic                      ui_rst,
   input  logic [1:0]                req_valid,
   output logic [1:0]                req_ready,
   input  logic [1:0]                req_rd,
   input  logic [2*ADDR_W-1:0]       req_addr,
   input  logic [2*DATA_W-1:0]       req_wdata,
   input  logic [2*(DATA_W/8)-1:0]   req_wmask,
   output logic [DATA_W-1:0]         rd_data,
   output logic [1:0]                rd_valid,
   output logic [ADDR_W-1:0]         app_addr,
   output logic [2:0]                app_cmd,
   output logic                      app_en,
   input  logic                      app_rdy,
   output logic [DATA_W-1:0]         app_wdf_data,
   output logic [DATA_W/8-1:0]       app_wdf_mask,
   output logic                      app_wdf_wren,
   output logic                      app_wdf_end,
   input  logic                      app_wdf_rdy,
   input  logic [DATA_W-1:0]         app_rd_data,
   input  logic                      app_rd_data_valid,
   output logic                      tag_err
);

   localparam int MASK_W = DATA_W / 8;

   arb_state_t        state;
   arb_state_t        state_nxt;
   logic              rr_ptr;
   logic [1:0]        cand;
   logic              gnt_any;
   logic              gnt_sel;
   logic              accept;
   logic              cmd_hs;
   logic              wdat_hs;
   logic              cmd_done;
   logic              wdat_done;
   logic              tag_push;

   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [MASK_W-1:0] wmask_q;
   logic              rd_q;
   logic              sel_q;

   logic              tag_full;
   logic              tag_empty;
   logic              tag_out;

   // Candidate filter and round-robin pick; reads wait while no tag slot is free
   always_comb begin
      cand    = req_valid & ~(req_rd & {2{tag_full}});
      gnt_any = |cand;
      gnt_sel = cand[rr_ptr] ? rr_ptr : ~rr_ptr;
   end

   // FSM next state and handshake strobes; each strobe drops once its own
   // handshake completes, and IDLE is re-entered when both are done
   always_comb begin
      state_nxt    = state;
      req_ready    = 2'b00;
      accept       = 1'b0;
      app_en       = 1'b0;
      app_wdf_wren = 1'b0;
      app_wdf_end  = 1'b0;
      cmd_hs       = 1'b0;
      wdat_hs      = 1'b0;
      tag_push     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (gnt_any) begin
               req_ready = onehot2(gnt_sel);
               accept    = 1'b1;
               state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            app_en       = ~cmd_done;
            app_wdf_wren = ~wdat_done;
            app_wdf_end  = ~wdat_done;
            cmd_hs       = app_en & app_rdy;
            wdat_hs      = app_wdf_wren & app_wdf_rdy;
            tag_push     = cmd_hs & rd_q;
            if ((cmd_done | cmd_hs) & (wdat_done | wdat_hs)) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // FSM state register
   always_ff @(posedge ui_clk or posedge ui_rst) begin
      if (ui_rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Latch the granted payload and advance the round-robin pointer
   always_ff @(posedge ui_clk or posedge ui_rst) begin
      if (ui_rst) begin
         rr_ptr  <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         wmask_q <= '0;
         rd_q    <= 1'b0;
         sel_q   <= 1'b0;
      end else if (accept) begin
         rr_ptr  <= ~gnt_sel;
         sel_q   <= gnt_sel;
         rd_q    <= req_rd[gnt_sel];
         addr_q  <= gnt_sel ? req_addr[ADDR_W +: ADDR_W]   : req_addr[0 +: ADDR_W];
         wdata_q <= gnt_sel ? req_wdata[DATA_W +: DATA_W]  : req_wdata[0 +: DATA_W];
         wmask_q <= gnt_sel ? req_wmask[MASK_W +: MASK_W]  : req_wmask[0 +: MASK_W];
      end
   end

   // Handshake completion flags; reads have no write-data phase
   always_ff @(posedge ui_clk or posedge ui_rst) begin
      if (ui_rst) begin
         cmd_done  <= 1'b0;
         wdat_done <= 1'b0;
      end else if (accept) begin
         cmd_done  <= 1'b0;
         wdat_done <= req_rd[gnt_sel];
      end else begin
         if (cmd_hs) begin
            cmd_done <= 1'b1;
         end
         if (wdat_hs) begin
            wdat_done <= 1'b1;
         end
      end
   end

   assign app_addr     = addr_q;
   assign app_cmd      = rd_q ? APP_CMD_RD : APP_CMD_WR;
   assign app_wdf_data = wdata_q;
   assign app_wdf_mask = wmask_q;

   ddr3_tag_fifo #(
      .TAG_DEPTH (TAG_DEPTH)
   ) u_tag_fifo (
      .clk      (ui_clk),
      .rst      (ui_rst),
      .push     (tag_push),
      .push_tag (sel_q),
      .pop      (app_rd_data_valid),
      .pop_tag  (tag_out),
      .full     (tag_full),
      .empty    (tag_empty)
   );

   // Read return: register data and steer the strobe by the popped tag;
   // a return with no outstanding tag is flagged and never strobed
   always_ff @(posedge ui_clk or posedge ui_rst) begin
      if (ui_rst) begin
         rd_data  <= '0;
         rd_valid <= 2'b00;
         tag_err  <= 1'b0;
      end else begin
         rd_valid <= 2'b00;
         if (app_rd_data_valid) begin
            rd_data <= app_rd_data;
            if (tag_empty) begin
               tag_err <= 1'b1;
            end else begin
               rd_valid <= onehot2(tag_out);
            end
         end
      end
   end

endmodule

// File: tb/tb_ddr3_app_arbiter.sv
// Directed bench for ddr3_app_arbiter: a per-cycle vector table for grant
// order, single writes and interleaved reads, plus sequences for stalled
// app_rdy, a full tag FIFO, tag errors and reset during ISSUE.
module tb_ddr3_app_arbiter;

   localparam int ADDR_W    = 28;
   localparam int DATA_W    = 256;
   localparam int MASK_W    = DATA_W / 8;
   localparam int TAG_DEPTH = 16;

   localparam logic [ADDR_W-1:0] A0 = 28'h100;
   localparam logic [ADDR_W-1:0] A1 = 28'h200;
   localparam logic [DATA_W-1:0] D0 = {32{8'hA5}};
   localparam logic [DATA_W-1:0] D1 = {32{8'h5A}};
   localparam logic [MASK_W-1:0] M0 = 32'h0000_0000;
   localparam logic [MASK_W-1:0] M1 = 32'hF0F0_000F;
   localparam logic [DATA_W-1:0] R1 = {128'h1, 128'h1111};
   localparam logic [DATA_W-1:0] R2 = {128'h2, 128'h2222};
   localparam logic [DATA_W-1:0] R3 = {128'h3, 128'h3333};

   logic                    ui_clk = 1'b0;
   logic                    ui_rst;
   logic [1:0]              req_valid;
   logic [1:0]              req_ready;
   logic [1:0]              req_rd;
   logic [2*ADDR_W-1:0]     req_addr;
   logic [2*DATA_W-1:0]     req_wdata;
   logic [2*MASK_W-1:0]     req_wmask;
   logic [DATA_W-1:0]       rd_data;
   logic [1:0]              rd_valid;
   logic [ADDR_W-1:0]       app_addr;
   logic [2:0]              app_cmd;
   logic                    app_en;
   logic                    app_rdy;
   logic [DATA_W-1:0]       app_wdf_data;
   logic [MASK_W-1:0]       app_wdf_mask;
   logic                    app_wdf_wren;
   logic                    app_wdf_end;
   logic                    app_wdf_rdy;
   logic [DATA_W-1:0]       app_rd_data;
   logic                    app_rd_data_valid;
   logic                    tag_err;

   int checks = 0;
   int errors = 0;

   always #5 ui_clk = ~ui_clk;

   ddr3_app_arbiter #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .TAG_DEPTH (TAG_DEPTH)
   ) dut (
      .ui_clk            (ui_clk),
      .ui_rst            (ui_rst),
      .req_valid         (req_valid),
      .req_ready         (req_ready),
      .req_rd            (req_rd),
      .req_addr          (req_addr),
      .req_wdata         (req_wdata),
      .req_wmask         (req_wmask),
      .rd_data           (rd_data),
      .rd_valid          (rd_valid),
      .app_addr          (app_addr),
      .app_cmd           (app_cmd),
      .app_en            (app_en),
      .app_rdy           (app_rdy),
      .app_wdf_data      (app_wdf_data),
      .app_wdf_mask      (app_wdf_mask),
      .app_wdf_wren      (app_wdf_wren),
      .app_wdf_end       (app_wdf_end),
      .app_wdf_rdy       (app_wdf_rdy),
      .app_rd_data       (app_rd_data),
      .app_rd_data_valid (app_rd_data_valid),
      .tag_err           (tag_err)
   );

   typedef struct {
      logic [1:0]        valid;
      logic [1:0]        rd;
      logic              rdv;
      logic [DATA_W-1:0] rdata;
      logic [1:0]        ready;
      logic              en;
      logic              wren;
      logic [2:0]        cmd;
      logic              sel;
      logic [1:0]        rvld;
      logic [DATA_W-1:0] rdat;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic [1:0] valid, input logic [1:0] rd,
                               input logic rdv, input logic [DATA_W-1:0] rdata,
                               input logic [1:0] ready, input logic en,
                               input logic wren, input logic [2:0] cmd,
                               input logic sel, input logic [1:0] rvld,
                               input logic [DATA_W-1:0] rdat);
      vec_t v;
      v.valid = valid; v.rd = rd; v.rdv = rdv; v.rdata = rdata;
      v.ready = ready; v.en = en; v.wren = wren; v.cmd = cmd;
      v.sel = sel; v.rvld = rvld; v.rdat = rdat;
      return v;
   endfunction

   task automatic chk(input string name, input logic [DATA_W-1:0] act,
                      input logic [DATA_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge ui_clk);
      #1;
   endtask

   task automatic do_reset();
      ui_rst = 1'b1;
      step();
      ui_rst = 1'b0;
   endtask

   // Wait (bounded) for req_ready[idx]; returns at the negedge of the accept cycle
   task automatic wait_ready(input int idx, input string name);
      int n;
      n = 0;
      @(negedge ui_clk);
      while (!req_ready[idx] && n < 20) begin
         @(negedge ui_clk);
         n++;
      end
      chk(name, 256'(req_ready[idx]), 256'(1'b1));
   endtask

   initial begin
      int en_cnt;
      int wren_cnt;
      int acc_cnt;
      logic en_hist [1:6];
      logic wren_hist [1:6];

      ui_rst            = 1'b1;
      req_valid         = 2'b00;
      req_rd            = 2'b00;
      req_addr          = {A1, A0};
      req_wdata         = {D1, D0};
      req_wmask         = {M1, M0};
      app_rdy           = 1'b1;
      app_wdf_rdy       = 1'b1;
      app_rd_data       = '0;
      app_rd_data_valid = 1'b0;

      // ---- reset state ----
      repeat (3) @(posedge ui_clk);
      @(negedge ui_clk);
      chk("rst req_ready", 256'(req_ready), 256'(2'b00));
      chk("rst app_en", 256'(app_en), 256'(1'b0));
      chk("rst wren", 256'(app_wdf_wren), 256'(1'b0));
      chk("rst wdf_end", 256'(app_wdf_end), 256'(1'b0));
      chk("rst app_cmd", 256'(app_cmd), 256'(3'b000));
      chk("rst app_addr", 256'(app_addr), 256'(0));
      chk("rst wdf_data", app_wdf_data, '0);
      chk("rst wdf_mask", 256'(app_wdf_mask), 256'(0));
      chk("rst rd_valid", 256'(rd_valid), 256'(2'b00));
      chk("rst rd_data", rd_data, '0);
      chk("rst tag_err", 256'(tag_err), 256'(1'b0));
      @(posedge ui_clk);
      #1;
      ui_rst = 1'b0;

      // ---- vector table ----
      // both requesters writing continuously: grants 0,1,0,1
      vecs.push_back(mk(2'b11, 2'b00, 0, '0, 2'b01, 0, 0, 3'b000, 0, 2'b00, '0));
      vecs.push_back(mk(2'b11, 2'b00, 0, '0, 2'b00, 1, 1, 3'b000, 0, 2'b00, '0));
      vecs.push_back(mk(2'b11, 2'b00, 0, '0, 2'b10, 0, 0, 3'b000, 0, 2'b00, '0));
      vecs.push_back(mk(2'b11, 2'b00, 0, '0, 2'b00, 1, 1, 3'b000, 1, 2'b00, '0));
      vecs.push_back(mk(2'b11, 2'b00, 0, '0, 2'b01, 0, 0, 3'b000, 0, 2'b00, '0));
      vecs.push_back(mk(2'b11, 2'b00, 0, '0, 2'b00, 1, 1, 3'b000, 0, 2'b00, '0));
      vecs.push_back(mk(2'b11, 2'b00, 0, '0, 2'b10, 0, 0, 3'b000, 0, 2'b00, '0));
      vecs.push_back(mk(2'b11, 2'b00, 0, '0, 2'b00, 1, 1, 3'b000, 1, 2'b00, '0));
      vecs.push_back(mk(2'b00, 2'b00, 0, '0, 2'b00, 0, 0, 3'b000, 0, 2'b00, '0));
      // single write from requester 0
      vecs.push_back(mk(2'b01, 2'b00, 0, '0, 2'b01, 0, 0, 3'b000, 0, 2'b00, '0));
      vecs.push_back(mk(2'b00, 2'b00, 0, '0, 2'b00, 1, 1, 3'b000, 0, 2'b00, '0));
      vecs.push_back(mk(2'b00, 2'b00, 0, '0, 2'b00, 0, 0, 3'b000, 0, 2'b00, '0));
      // reads req0, req1, req0 then three in-order returns
      vecs.push_back(mk(2'b01, 2'b11, 0, '0, 2'b01, 0, 0, 3'b000, 0, 2'b00, '0));
      vecs.push_back(mk(2'b00, 2'b11, 0, '0, 2'b00, 1, 0, 3'b001, 0, 2'b00, '0));
      vecs.push_back(mk(2'b10, 2'b11, 0, '0, 2'b10, 0, 0, 3'b000, 0, 2'b00, '0));
      vecs.push_back(mk(2'b00, 2'b11, 0, '0, 2'b00, 1, 0, 3'b001, 1, 2'b00, '0));
      vecs.push_back(mk(2'b01, 2'b11, 0, '0, 2'b01, 0, 0, 3'b000, 0, 2'b00, '0));
      vecs.push_back(mk(2'b00, 2'b11, 0, '0, 2'b00, 1, 0, 3'b001, 0, 2'b00, '0));
      vecs.push_back(mk(2'b00, 2'b00, 1, R1, 2'b00, 0, 0, 3'b000, 0, 2'b00, '0));
      vecs.push_back(mk(2'b00, 2'b00, 1, R2, 2'b00, 0, 0, 3'b000, 0, 2'b01, R1));
      vecs.push_back(mk(2'b00, 2'b00, 1, R3, 2'b00, 0, 0, 3'b000, 0, 2'b10, R2));
      vecs.push_back(mk(2'b00, 2'b00, 0, '0, 2'b00, 0, 0, 3'b000, 0, 2'b01, R3));
      vecs.push_back(mk(2'b00, 2'b00, 0, '0, 2'b00, 0, 0, 3'b000, 0, 2'b00, '0));

      for (int i = 0; i < vecs.size(); i++) begin
         req_valid         = vecs[i].valid;
         req_rd            = vecs[i].rd;
         app_rd_data_valid = vecs[i].rdv;
         app_rd_data       = vecs[i].rdata;
         @(negedge ui_clk);
         chk($sformatf("v%0d req_ready", i), 256'(req_ready), 256'(vecs[i].ready));
         chk($sformatf("v%0d app_en", i), 256'(app_en), 256'(vecs[i].en));
         chk($sformatf("v%0d wren", i), 256'(app_wdf_wren), 256'(vecs[i].wren));
         chk($sformatf("v%0d wdf_end", i), 256'(app_wdf_end), 256'(vecs[i].wren));
         chk($sformatf("v%0d rd_valid", i), 256'(rd_valid), 256'(vecs[i].rvld));
         if (vecs[i].en) begin
            chk($sformatf("v%0d app_cmd", i), 256'(app_cmd), 256'(vecs[i].cmd));
            chk($sformatf("v%0d app_addr", i), 256'(app_addr),
                256'(vecs[i].sel ? A1 : A0));
         end
         if (vecs[i].wren) begin
            chk($sformatf("v%0d wdf_data", i), app_wdf_data, vecs[i].sel ? D1 : D0);
            chk($sformatf("v%0d wdf_mask", i), 256'(app_wdf_mask),
                256'(vecs[i].sel ? M1 : M0));
         end
         if (vecs[i].rvld != 2'b00) begin
            chk($sformatf("v%0d rd_data", i), rd_data, vecs[i].rdat);
         end
         step();
      end
      app_rd_data_valid = 1'b0;

      // ---- write with app_rdy delayed 3 cycles ----
      app_rdy   = 1'b0;
      req_valid = 2'b01;
      req_rd    = 2'b00;
      @(negedge ui_clk);
      chk("dly accept", 256'(req_ready), 256'(2'b01));
      step();
      req_valid = 2'b00;
      en_cnt = 0; wren_cnt = 0; acc_cnt = 0;
      for (int k = 1; k <= 6; k++) begin
         app_rdy = (k >= 4);
         @(negedge ui_clk);
         en_hist[k]   = app_en;
         wren_hist[k] = app_wdf_wren;
         if (app_en) en_cnt++;
         if (app_wdf_wren) wren_cnt++;
         if (req_ready != 2'b00) acc_cnt++;
         step();
      end
      for (int k = 1; k <= 6; k++) begin
         chk($sformatf("dly en c%0d", k), 256'(en_hist[k]), 256'(k <= 4));
         chk($sformatf("dly wren c%0d", k), 256'(wren_hist[k]), 256'(k == 1));
      end
      chk("dly en cycles", 256'(en_cnt), 256'(4));
      chk("dly wren cycles", 256'(wren_cnt), 256'(1));
      chk("dly extra accepts", 256'(acc_cnt), 256'(0));

      // ---- fill the tag FIFO with 16 reads ----
      do_reset();
      app_rdy = 1'b1;
      for (int n = 0; n < TAG_DEPTH; n++) begin
         req_valid = 2'b01;
         req_rd    = 2'b01;
         wait_ready(0, $sformatf("fill rd%0d", n));
         step();
         req_valid = 2'b00;
         step();
      end
      req_valid = 2'b11;
      req_rd    = 2'b01;
      @(negedge ui_clk);
      chk("full write granted", 256'(req_ready), 256'(2'b10));
      step();
      req_valid = 2'b01;
      @(negedge ui_clk);
      chk("full write en", 256'(app_en), 256'(1'b1));
      chk("full write wren", 256'(app_wdf_wren), 256'(1'b1));
      step();
      @(negedge ui_clk);
      chk("full read stall", 256'(req_ready), 256'(2'b00));
      step();
      app_rd_data_valid = 1'b1;
      app_rd_data       = R1;
      @(negedge ui_clk);
      chk("full pop same cycle", 256'(req_ready), 256'(2'b00));
      step();
      app_rd_data_valid = 1'b0;
      @(negedge ui_clk);
      chk("slot freed grant", 256'(req_ready), 256'(2'b01));
      chk("slot freed rd_valid", 256'(rd_valid), 256'(2'b01));
      chk("slot freed rd_data", rd_data, R1);
      step();
      req_valid = 2'b00;
      step();

      // ---- read return with empty tag FIFO ----
      do_reset();
      @(negedge ui_clk);
      chk("tagerr cleared", 256'(tag_err), 256'(1'b0));
      step();
      app_rd_data_valid = 1'b1;
      app_rd_data       = R2;
      step();
      app_rd_data_valid = 1'b0;
      @(negedge ui_clk);
      chk("tagerr set", 256'(tag_err), 256'(1'b1));
      chk("tagerr rd_valid", 256'(rd_valid), 256'(2'b00));
      step();
      @(negedge ui_clk);
      chk("tagerr sticky", 256'(tag_err), 256'(1'b1));
      ui_rst = 1'b1;
      #1;
      chk("tagerr async clear", 256'(tag_err), 256'(1'b0));
      step();
      ui_rst = 1'b0;

      // ---- reset while in ISSUE ----
      app_rdy   = 1'b0;
      req_valid = 2'b01;
      req_rd    = 2'b00;
      @(negedge ui_clk);
      chk("midrst accept", 256'(req_ready), 256'(2'b01));
      step();
      req_valid = 2'b00;
      @(negedge ui_clk);
      chk("midrst en before", 256'(app_en), 256'(1'b1));
      #1;
      ui_rst = 1'b1;
      #1;
      chk("midrst en drop", 256'(app_en), 256'(1'b0));
      chk("midrst wren drop", 256'(app_wdf_wren), 256'(1'b0));
      step();
      ui_rst  = 1'b0;
      app_rdy = 1'b1;
      @(negedge ui_clk);
      chk("midrst idle after", 256'(app_en), 256'(1'b0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global bound so the run can never hang
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/ddr3_app_arbiter.md
# ddr3_app_arbiter

Two-requester arbiter for the MIG 7-series user (app) interface, on ui_clk. Accepts single-beat write/read commands from two independent requesters, grants them round-robin, sequences app_en/app_wdf_wren handshakes, and routes in-order read data back to the issuing requester through a tag FIFO. Sits between ddr3_app_drv-style traffic sources and the ddr3 MIG core.

## Interface
- ADDR_W, 28, app address width
- DATA_W, 256, app data width (mask width DATA_W/8)
- TAG_DEPTH, 16, outstanding-read tag FIFO depth (power of 2)
- ui_clk  in  1  MIG user clock, all logic rising-edge
- ui_rst  in  1  reset, asynchronous, active-high (ui_clk_sync_rst)
- req_valid  in  2  per-requester command valid
- req_ready  out  2  one-cycle accept pulse, one-hot or zero
- req_rd  in  2  1 = read, 0 = write
- req_addr  in  2*ADDR_W  packed, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  2*DATA_W  packed write data
- req_wmask  in  2*DATA_W/8  packed write mask (1 = byte masked)
- rd_data  out  DATA_W  returned read data, shared by both requesters
- rd_valid  out  2  one-hot read-return strobe
- app_addr / app_cmd / app_en  out  ADDR_W / 3 / 1  MIG command
- app_rdy  in  1  MIG command accept
- app_wdf_data / app_wdf_mask / app_wdf_wren / app_wdf_end  out  DATA_W / DATA_W/8 / 1 / 1
- app_wdf_rdy  in  1
- app_rd_data / app_rd_data_valid  in  DATA_W / 1
- tag_err  out  1  sticky: read data returned with tag FIFO empty

## Operation
- States: IDLE, ISSUE.
- IDLE: candidates = req_valid, with reads masked off while tag FIFO full. If any candidate, grant by round-robin: rr_ptr names preferred requester; otherwise the other. Pulse req_ready[g], latch addr/cmd/wdata/wmask/rd flag, rr_ptr <= ~g, go ISSUE.
- ISSUE: app_en=1, app_cmd=3'b001 read / 3'b000 write. Write also drives app_wdf_wren=app_wdf_end=1. cmd_done set on app_en&app_rdy; wdat_done on wren&app_wdf_rdy (reads: wdat_done preset 1). Each strobe drops independently once its handshake completes. When both done (may be same cycle) -> IDLE. Read push of g into tag FIFO at command acceptance.
- Read return: on app_rd_data_valid pop tag; next cycle rd_data <= app_rd_data, rd_valid <= one-hot(tag). Pop with FIFO empty: rd_valid stays 0, tag_err <= 1.
- Simultaneous push and pop: both occur, count unchanged; full with pop same cycle still blocks new read grant (full evaluated on registered count).
- Writes never blocked by tag FIFO.

## Timing
- Reset values: req_ready=0, rd_valid=0, rd_data=0, app_en=0, app_wdf_wren=0, app_wdf_end=0, app_cmd=0, app_addr=0, wdf data/mask=0, tag_err=0, rr_ptr=0, FIFO empty, state IDLE.
- Accept at cycle t (req_ready high) -> app_en high at t+1; earliest return to IDLE t+1, next accept t+2. Peak one command per 2 cycles.
- Read data: app_rd_data_valid at t -> rd_valid at t+1.
- Requester must hold valid/payload until req_ready; payload sampled in accept cycle.
- Reset mid-ISSUE: strobes drop asynchronously, in-flight tags lost; reads then returning set tag_err.

## Structure
- Shared package ddr3_pkg: APP_CMD_WR=3'b000, APP_CMD_RD=3'b001, state encodings.
- One sub-module: ddr3_tag_fifo (1-bit wide, TAG_DEPTH, push/pop/full/empty, registered count).

## Test plan
- Single write req0 addr 0x100, data 0xA5 pattern, app_rdy/app_wdf_rdy=1 -> app_en and wren both one cycle, app_cmd=000, app_addr=0x100.
- Both valid continuously from reset -> grant order 0,1,0,1; no requester granted twice consecutively.
- Write with app_rdy delayed 3 cycles, app_wdf_rdy immediate -> wren drops after 1 cycle, app_en held 4 cycles, one accept only.
- Interleaved reads req0,req1,req0 with model returning in order -> rd_valid = 01,10,01, data matches.
- 16 reads outstanding, no return -> 17th read stalls, writes still granted; one return frees slot next cycle.
- app_rd_data_valid with empty FIFO -> tag_err=1, rd_valid=0; ui_rst clears it.
